mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Store-fed byte FIFO drains into a register-driven serial line.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR = 32'h0000_1000,
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] CTL_ADDR = TX_ADDR + 32'd4;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic [7:0]  shift, shift_n;
  logic [2:0]  bitc, bitc_n;
  logic [15:0] baud, baud_n;
  logic        tx_q, tx_n;
  logic        ovf_q;

  logic tx_hit, ctl_hit;
  logic pop, push, drop;
  logic unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  assign tx_hit  = MemWrite && (DataAdr == TX_ADDR);
  assign ctl_hit = MemWrite && (DataAdr == CTL_ADDR);

  assign full = (count == FULL_C);
  assign pop  = (state == IDLE) && (count != '0);
  assign push = tx_hit && (!full || pop);
  assign drop = tx_hit && full && !pop;

  assign tx   = tx_q;
  assign ovf  = ovf_q;
  assign busy = (state != IDLE) || (count != '0);

  // FIFO storage, no reset needed: only read below count
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= WriteData[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky overflow; a drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ctl_hit && WriteData[0]) begin
      ovf_q <= 1'b0;
    end
  end

  // serializer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      bitc  <= '0;
      baud  <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bitc  <= bitc_n;
      baud  <= baud_n;
      tx_q  <= tx_n;
    end
  end

  // frame sequencing; pop only from IDLE keeps a gap
  always_comb begin
    state_n = state;
    shift_n = shift;
    bitc_n  = bitc;
    baud_n  = baud;
    case (state)
      IDLE: begin
        if (pop) begin
          state_n = START;
          shift_n = mem[rptr];
          bitc_n  = '0;
          baud_n  = '0;
        end
      end
      START: begin
        if (baud == BAUD_MAX) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      DATA: begin
        if (baud == BAUD_MAX) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bitc == 3'd7) begin
            state_n = STOP;
          end else begin
            bitc_n = bitc + 3'd1;
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      STOP: begin
        if (baud == BAUD_MAX) begin
          baud_n  = '0;
          state_n = IDLE;
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // line level for the upcoming cycle, registered
  always_comb begin
    tx_n = 1'b1;
    unique case (1'b1)
      (state_n == START): tx_n = 1'b0;
      (state_n == DATA):  tx_n = shift_n[0];
      default:            tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx.
// Decodes the serial line and checks bytes.
module tb_mmio_uart_tx;

  localparam logic [31:0] TXA = 32'h0000_1000;
  localparam int CPB = 4;
  localparam int DEP = 4;

  logic        clk;
  logic        rst_n;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        tx;
  logic        busy;
  logic        full;
  logic        ovf;

  int checks;
  int failures;

  logic [7:0] rxq [$];
  logic       rx_act;
  int         rc;
  logic [7:0] rsh;
  int         ferr;
  int         txlow;

  mmio_uart_tx #(
    .TX_ADDR(TXA),
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .MemWrite(MemWrite),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .tx(tx),
    .busy(busy),
    .full(full),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // serial receiver, samples mid-bit on falling clock
  initial begin
    rx_act = 1'b0;
    rc = 0;
    rsh = '0;
    ferr = 0;
  end
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_act = 1'b0;
      rc = 0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act = 1'b1;
        rc = 0;
      end
    end else begin
      rc = rc + 1;
      if (rc >= 6 && rc <= 34 && (rc % 4) == 2)
        rsh[(rc - 6) / 4] = tx;
      if (rc == 38) begin
        if (tx === 1'b1) rxq.push_back(rsh);
        else ferr = ferr + 1;
        rx_act = 1'b0;
      end
    end
  end

  // count low line cycles outside reset
  initial txlow = 0;
  always @(negedge clk) begin
    if (rst_n && tx === 1'b0) txlow = txlow + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_busy", {31'd0, busy}, 32'd0);
    cyc(2);
  endtask

  function automatic logic [7:0] rxb(input int idx);
    if (idx < rxq.size()) return rxq[idx];
    return 8'hxx;
  endfunction

  initial begin
    int base;
    int lowb;
    logic [7:0] b;
    logic [7:0] e;
    logic expb;
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;

    // reset state
    #23;
    chk("rst_tx",   {31'd0, tx},   32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single 0xA5 frame, first store after release
    base = rxq.size();
    b = 8'hA5;
    store(TXA, 32'h0000_00A5);
    chk("a5_pre_tx",   {31'd0, tx},   32'd1);
    chk("a5_pre_busy", {31'd0, busy}, 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c < CPB) expb = 1'b0;
      else if (c >= 9 * CPB) expb = 1'b1;
      else expb = b[(c / CPB) - 1];
      chk("a5_frame", {31'd0, tx}, {31'd0, expb});
    end
    chk("a5_busy40", {31'd0, busy}, 32'd1);
    cyc(1);
    chk("a5_busy41", {31'd0, busy}, 32'd0);
    chk("a5_idle_tx", {31'd0, tx}, 32'd1);
    cyc(2);
    chk("a5_rx_n", rxq.size() - base, 32'd1);
    chk("a5_rx", {24'd0, rxb(base)}, 32'hA5);

    // overflow: FSM busy, five stores, last dropped
    base = rxq.size();
    store(TXA, 32'h0000_0010);
    for (int i = 0; i < 5; i++)
      store(TXA, 32'h11 + i);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_set",  {31'd0, ovf},  32'd1);
    wait_idle(400);
    chk("ovf_rx_n", rxq.size() - base, 32'd5);
    for (int i = 0; i < 5; i++)
      chk("ovf_rx", {24'd0, rxb(base + i)}, 32'h10 + i);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // control register and unmapped store
    store(TXA + 32'd4, 32'hFFFF_FFFE);
    chk("ctl_bit0_0", {31'd0, ovf}, 32'd1);
    store(TXA + 32'd4, 32'h0000_0001);
    chk("ctl_clear", {31'd0, ovf}, 32'd0);
    base = rxq.size();
    lowb = txlow;
    store(32'd100, 32'd25);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_full", {31'd0, full}, 32'd0);
    cyc(20);
    chk("stray_tx", {31'd0, tx}, 32'd1);
    chk("stray_low", txlow - lowb, 32'd0);
    chk("stray_rx", rxq.size() - base, 32'd0);

    // full FIFO store in the same cycle as IDLE pop
    base = rxq.size();
    store(TXA, 32'h20);
    for (int i = 1; i < 5; i++)
      store(TXA, 32'h20 + i);
    chk("pp_full", {31'd0, full}, 32'd1);
    cyc(37);
    chk("pp_gap_tx",   {31'd0, tx},   32'd1);
    chk("pp_gap_full", {31'd0, full}, 32'd1);
    store(TXA, 32'h25);
    chk("pp_full2", {31'd0, full}, 32'd1);
    chk("pp_ovf",   {31'd0, ovf},  32'd0);
    wait_idle(400);
    chk("pp_rx_n", rxq.size() - base, 32'd6);
    for (int i = 0; i < 6; i++)
      chk("pp_rx", {24'd0, rxb(base + i)}, 32'h20 + i);
    chk("pp_ovf_end", {31'd0, ovf}, 32'd0);

    // reset during DATA of 0x3C with two queued
    base = rxq.size();
    store(TXA, 32'h3C);
    store(TXA, 32'h3D);
    store(TXA, 32'h3E);
    cyc(3);
    chk("rs_bit0", {31'd0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_tx",   {31'd0, tx},   32'd1);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_full", {31'd0, full}, 32'd0);
    #10;
    rst_n = 1'b1;
    lowb = txlow;
    cyc(100);
    chk("rs_after_busy", {31'd0, busy}, 32'd0);
    chk("rs_after_low", txlow - lowb, 32'd0);
    chk("rs_after_rx", rxq.size() - base, 32'd0);

    // paced bytes wrap both pointers twice
    base = rxq.size();
    for (int i = 0; i < 2 * DEP + 1; i++) begin
      e = 8'h40 + 8'(i * 19);
      store(TXA, {24'hABCDEF, e});
      cyc(44);
    end
    wait_idle(200);
    chk("wr_rx_n", rxq.size() - base, 2 * DEP + 1);
    for (int i = 0; i < 2 * DEP + 1; i++) begin
      e = 8'h40 + 8'(i * 19);
      chk("wr_rx", {24'd0, rxb(base + i)}, {24'd0, e});
    end
    chk("wr_ovf", {31'd0, ovf}, 32'd0);
    chk("frame_err", ferr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
